// File: rtl/slowbus_ctrl.sv
// slowbus_ctrl: cycle sequencer for the slow 6800-family peripheral bus.
// Generates the free-running peripheral clock and aligns each CPU access to it.
// It drives one chip enable per device and ends the cycle with an 8-bit DSACK.
// Optional feature macro: SLOWBUS_TIMEOUT_EN. When defined, an access that stays
// unacknowledged for TIMEOUT cycles is terminated with a bus error.
module slowbus_ctrl #(
    parameter int unsigned CLK_DIV  = 25,
    parameter int unsigned CE_START = 8,
    parameter int unsigned NUM_DEV  = 2,
    parameter int unsigned SEL_CODE = 7,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic               sys_clk,
    input  logic               n_reset,
    input  logic               n_as,
    input  logic               addr31,
    input  logic [2:0]         addr_sel,
    input  logic [1:0]         addr_dev,
    output logic [1:0]         n_dsack,
    output logic               periph_clk,
    output logic [NUM_DEV-1:0] n_ce,
    output logic               n_buf_oe,
    output logic               n_berr
);

    localparam int unsigned DivW = $clog2(CLK_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV / 2);
    localparam logic [DivW-1:0] DivCe   = DivW'(CE_START);

    typedef enum logic [2:0] {
        StIdle,
        StAlign,
        StActive,
        StTerm,
        StHold,
        StBerr
    } state_e;

    state_e             state_q;
    logic [DivW-1:0]    div_cnt_q;
    logic               periph_clk_q;
    logic [1:0]         dev_q;
    logic [NUM_DEV-1:0] n_ce_q;
    logic               n_buf_oe_q;
    logic               n_dsack0_q;
    logic               hit;
    logic               tmo_fire;
    logic [NUM_DEV-1:0] ce_sel;

    assign hit = !n_as && !addr31 && (addr_sel == 3'(SEL_CODE))
                 && (32'(addr_dev) < NUM_DEV);

    // Active-low one-hot enable for the device latched at request time.
    assign ce_sel = ~(NUM_DEV'(1) << dev_q);

    // Free-running divider producing the peripheral clock; never touched by the FSM.
    always_ff @(posedge sys_clk or negedge n_reset) begin
        if (!n_reset) begin
            div_cnt_q    <= '0;
            periph_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= (div_cnt_q == DivLast) ? '0 : div_cnt_q + 1'b1;
            if (div_cnt_q == DivHalf) begin
                periph_clk_q <= 1'b1;
            end else if (div_cnt_q == DivLast) begin
                periph_clk_q <= 1'b0;
            end
        end
    end

`ifdef SLOWBUS_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;
    logic       n_berr_q;

    // Counts strobe-low cycles of an unfinished access; cleared whenever nAS is high.
    always_ff @(posedge sys_clk or negedge n_reset) begin
        if (!n_reset) begin
            tmo_cnt_q <= '0;
        end else if (n_as) begin
            tmo_cnt_q <= '0;
        end else if (state_q != StHold && state_q != StBerr && tmo_cnt_q != 8'hff) begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end
    end

    // Fires on the TIMEOUT-th consecutive low-strobe edge.
    assign tmo_fire = !n_as && state_q != StHold && state_q != StBerr
                      && (tmo_cnt_q == 8'(TIMEOUT - 1));
    assign n_berr   = n_berr_q;
`else
    assign tmo_fire = 1'b0;
    assign n_berr   = 1'b1;
`endif

    // Access sequencer with registered outputs; abort on nAS high has top priority.
    always_ff @(posedge sys_clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= StIdle;
            dev_q      <= '0;
            n_ce_q     <= '1;
            n_buf_oe_q <= 1'b1;
            n_dsack0_q <= 1'b1;
`ifdef SLOWBUS_TIMEOUT_EN
            n_berr_q   <= 1'b1;
`endif
        end else if (tmo_fire) begin
            state_q    <= StBerr;
            n_ce_q     <= '1;
            n_buf_oe_q <= 1'b1;
            n_dsack0_q <= 1'b1;
`ifdef SLOWBUS_TIMEOUT_EN
            n_berr_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (hit) begin
                        dev_q   <= addr_dev;
                        state_q <= StAlign;
                    end
                end
                StAlign: begin
                    if (n_as) begin
                        state_q <= StIdle;
                    end else if (div_cnt_q == DivCe) begin
                        state_q    <= StActive;
                        n_ce_q     <= ce_sel;
                        n_buf_oe_q <= 1'b0;
                    end
                end
                StActive: begin
                    if (n_as) begin
                        state_q    <= StIdle;
                        n_ce_q     <= '1;
                        n_buf_oe_q <= 1'b1;
                    end else if (div_cnt_q == DivLast) begin
                        state_q    <= StTerm;
                        n_dsack0_q <= 1'b0;
                    end
                end
                StTerm: begin
                    // Abort here must also swallow the DSACK already on the bus.
                    n_ce_q <= '1;
                    if (n_as) begin
                        state_q    <= StIdle;
                        n_buf_oe_q <= 1'b1;
                        n_dsack0_q <= 1'b1;
                    end else begin
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    if (n_as) begin
                        state_q    <= StIdle;
                        n_buf_oe_q <= 1'b1;
                        n_dsack0_q <= 1'b1;
                    end
                end
`ifdef SLOWBUS_TIMEOUT_EN
                StBerr: begin
                    if (n_as) begin
                        state_q  <= StIdle;
                        n_berr_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q    <= StIdle;
                    n_ce_q     <= '1;
                    n_buf_oe_q <= 1'b1;
                    n_dsack0_q <= 1'b1;
                end
            endcase
        end
    end

    assign n_dsack    = {1'b1, n_dsack0_q};
    assign periph_clk = periph_clk_q;
    assign n_ce       = n_ce_q;
    assign n_buf_oe   = n_buf_oe_q;

endmodule
